// File: rtl/prng_generator_if.sv
// prng_generator_if: AXI4-Lite control and AXI4-Stream output bundle for prng_generator
//   slave  : prng_generator side (accepts control accesses, sources the bit stream)
//   master : bus driver / stream consumer side
//   s_axi_control_* : 6-bit address, 32-bit data AXI4-Lite control channel
//   out_stream_*    : 8-bit AXI4-Stream, one pseudo-random bit per beat in TDATA[0]
interface prng_generator_if;
    logic        s_axi_control_AWVALID;
    logic        s_axi_control_AWREADY;
    logic [5:0]  s_axi_control_AWADDR;
    logic        s_axi_control_WVALID;
    logic        s_axi_control_WREADY;
    logic [31:0] s_axi_control_WDATA;
    logic [3:0]  s_axi_control_WSTRB;
    logic        s_axi_control_BVALID;
    logic        s_axi_control_BREADY;
    logic [1:0]  s_axi_control_BRESP;
    logic        s_axi_control_ARVALID;
    logic        s_axi_control_ARREADY;
    logic [5:0]  s_axi_control_ARADDR;
    logic        s_axi_control_RVALID;
    logic        s_axi_control_RREADY;
    logic [31:0] s_axi_control_RDATA;
    logic [1:0]  s_axi_control_RRESP;
    logic [7:0]  out_stream_TDATA;
    logic        out_stream_TVALID;
    logic        out_stream_TREADY;
    logic        out_stream_TLAST;

    modport slave (
        input  s_axi_control_AWVALID, s_axi_control_AWADDR,
        input  s_axi_control_WVALID, s_axi_control_WDATA, s_axi_control_WSTRB,
        input  s_axi_control_BREADY,
        input  s_axi_control_ARVALID, s_axi_control_ARADDR,
        input  s_axi_control_RREADY,
        input  out_stream_TREADY,
        output s_axi_control_AWREADY, s_axi_control_WREADY,
        output s_axi_control_BVALID, s_axi_control_BRESP,
        output s_axi_control_ARREADY,
        output s_axi_control_RVALID, s_axi_control_RDATA, s_axi_control_RRESP,
        output out_stream_TDATA, out_stream_TVALID, out_stream_TLAST
    );

    modport master (
        output s_axi_control_AWVALID, s_axi_control_AWADDR,
        output s_axi_control_WVALID, s_axi_control_WDATA, s_axi_control_WSTRB,
        output s_axi_control_BREADY,
        output s_axi_control_ARVALID, s_axi_control_ARADDR,
        output s_axi_control_RREADY,
        output out_stream_TREADY,
        input  s_axi_control_AWREADY, s_axi_control_WREADY,
        input  s_axi_control_BVALID, s_axi_control_BRESP,
        input  s_axi_control_ARREADY,
        input  s_axi_control_RVALID, s_axi_control_RDATA, s_axi_control_RRESP,
        input  out_stream_TDATA, out_stream_TVALID, out_stream_TLAST
    );
endinterface

// File: rtl/prng_generator.sv
// prng_generator: logistic-map pseudo-random bit streamer with an AXI4-Lite control slave
//   ap_clk   : single clock, all logic on the rising edge
//   ap_rst_n : asynchronous active-low reset
//   bus      : prng_generator_if.slave
//              control registers: 0x00 CTRL {idle, done, start}, 0x10 SEED (Q0.32),
//              0x1C N_BITS (bits per iteration, clamped 1..8), 0x24 NUM_BITS (beats per run)
//              stream: TDATA = {7'b0, bit}, MSB of the map state first, TLAST on the final beat
module prng_generator #(
    parameter logic [31:0] R_Q      = 32'hFFFE5C92,
    parameter logic [31:0] DEF_SEED = 32'h9E3779B9
) (
    input logic             ap_clk,
    input logic             ap_rst_n,
    prng_generator_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, CALC, EMIT, DONE} state_t;

    state_t      state;
    logic        aw_rdy, bvalid, rvalid, tvalid, tlast, tbit, ap_start, ap_done;
    logic [31:0] rdata, seed, n_bits, num_bits, x, total, cnt, xn, xc, rd_mux;
    logic [63:0] p_t, p_r;
    logic [3:0]  n_eff;
    logic [2:0]  k;
    logic        wr, rd, unused;

    assign wr = aw_rdy && bus.s_axi_control_AWVALID && bus.s_axi_control_WVALID;
    assign rd = aw_rdy && !rvalid && bus.s_axi_control_ARVALID;

    assign bus.s_axi_control_AWREADY = aw_rdy;
    assign bus.s_axi_control_WREADY  = aw_rdy;
    assign bus.s_axi_control_BVALID  = bvalid;
    assign bus.s_axi_control_BRESP   = 2'b00;
    assign bus.s_axi_control_ARREADY = aw_rdy && !rvalid;
    assign bus.s_axi_control_RVALID  = rvalid;
    assign bus.s_axi_control_RDATA   = rdata;
    assign bus.s_axi_control_RRESP   = 2'b00;
    assign bus.out_stream_TDATA      = {7'b0, tbit};
    assign bus.out_stream_TVALID     = tvalid;
    assign bus.out_stream_TLAST      = tlast;

    // x is never zero while iterating, so 2^32 - x equals -x in 32 bits
    assign p_t = {32'b0, x} * {32'b0, -x};
    assign p_r = {32'b0, R_Q} * {32'b0, p_t[63:32]};
    assign xn  = p_r[61:30];
    assign xc  = xn == 32'b0 ? DEF_SEED : xn;

    assign rd_mux = bus.s_axi_control_ARADDR == 6'h00 ? {29'b0, state == IDLE, ap_done, ap_start} :
                    bus.s_axi_control_ARADDR == 6'h10 ? seed :
                    bus.s_axi_control_ARADDR == 6'h1C ? n_bits :
                    bus.s_axi_control_ARADDR == 6'h24 ? num_bits : 32'b0;

    assign unused = &{1'b0, bus.s_axi_control_WSTRB, p_t[31:0], p_r[63:62], p_r[29:0]};

    // Write channel: always ready after reset, responses to back-to-back writes coalesce
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            aw_rdy   <= 1'b0;
            bvalid   <= 1'b0;
            seed     <= 32'b0;
            n_bits   <= 32'b0;
            num_bits <= 32'b0;
        end else begin
            aw_rdy <= 1'b1;
            bvalid <= wr ? 1'b1 : (bus.s_axi_control_BREADY ? 1'b0 : bvalid);
            if (wr && bus.s_axi_control_AWADDR == 6'h10) seed <= bus.s_axi_control_WDATA;
            if (wr && bus.s_axi_control_AWADDR == 6'h1C) n_bits <= bus.s_axi_control_WDATA;
            if (wr && bus.s_axi_control_AWADDR == 6'h24) num_bits <= bus.s_axi_control_WDATA;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rvalid <= 1'b0;
            rdata  <= 32'b0;
        end else begin
            rvalid <= rd ? 1'b1 : (bus.s_axi_control_RREADY ? 1'b0 : rvalid);
            if (rd) rdata <= rd_mux;
        end
    end

    // Run control; the configuration is snapshotted in LOAD so writes during a run
    // only affect the next start
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= IDLE;
            ap_start <= 1'b0;
            ap_done  <= 1'b0;
            x        <= 32'b0;
            total    <= 32'b0;
            cnt      <= 32'b0;
            n_eff    <= 4'd1;
            k        <= 3'd0;
            tvalid   <= 1'b0;
            tlast    <= 1'b0;
            tbit     <= 1'b0;
        end else begin
            if (wr && bus.s_axi_control_AWADDR == 6'h00 && bus.s_axi_control_WDATA[0] && state == IDLE)
                ap_start <= 1'b1;
            if (rd && bus.s_axi_control_ARADDR == 6'h00) ap_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        ap_start <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    x       <= seed == 32'b0 ? DEF_SEED : seed;
                    total   <= num_bits;
                    n_eff   <= n_bits == 32'b0 ? 4'd1 : (n_bits > 32'd8 ? 4'd8 : n_bits[3:0]);
                    cnt     <= 32'b0;
                    ap_done <= 1'b0;
                    state   <= num_bits == 32'b0 ? DONE : CALC;
                end
                CALC: begin
                    x      <= xc;
                    k      <= 3'd0;
                    tvalid <= 1'b1;
                    tbit   <= xc[31];
                    tlast  <= cnt + 32'd1 == total;
                    state  <= EMIT;
                end
                EMIT: begin
                    if (bus.out_stream_TREADY) begin
                        cnt <= cnt + 32'd1;
                        k   <= k + 3'd1;
                        if (tlast) begin
                            tvalid <= 1'b0;
                            tlast  <= 1'b0;
                            state  <= DONE;
                        end else if ({1'b0, k} == n_eff - 4'd1) begin
                            tvalid <= 1'b0;
                            tlast  <= 1'b0;
                            state  <= CALC;
                        end else begin
                            // next beat is bit 31-(k+1) of the current map state
                            tbit  <= x[5'd30 - 5'(k)];
                            tlast <= cnt + 32'd2 == total;
                        end
                    end
                end
                DONE: begin
                    ap_done <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prng_generator.sv
// tb_prng_generator: randomized scoreboard bench for prng_generator
module tb_prng_generator;
    localparam logic [31:0] R_Q      = 32'hFFFE5C92;
    localparam logic [31:0] DEF_SEED = 32'h9E3779B9;

    typedef struct packed {logic b; logic last; logic gap;} beat_t;

    logic  ap_clk = 1'b0;
    logic  ap_rst_n = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;
    beat_t exp_q[$];
    bit    mon_en = 1'b0;
    bit    rnd_ready = 1'b0;

    prng_generator_if ifc();
    prng_generator dut (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(ifc.slave));

    always #5 ap_clk = ~ap_clk;

    function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endfunction

    // Reference: iterate the logistic map on plain 64-bit integers and slice n bits per step
    function automatic void push_run(input logic [31:0] s, input logic [31:0] nb, input logic [31:0] num);
        longint unsigned x, t;
        int n, j;
        beat_t e;
        x = (s == 32'b0) ? 64'(DEF_SEED) : 64'(s);
        n = (nb == 32'b0) ? 1 : (nb > 32'd8) ? 8 : int'(nb);
        for (int i = 0; i < int'(num); i++) begin
            j = i % n;
            if (j == 0) begin
                t = (x * ((64'd1 << 32) - x)) >> 32;
                x = ((64'(R_Q) * t) >> 30) & 64'hFFFF_FFFF;
                if (x == 0) x = 64'(DEF_SEED);
            end
            e.b    = x[31 - j];
            e.last = (i == int'(num) - 1);
            e.gap  = e.last || (j == n - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d);
        int n = 0;
        ifc.s_axi_control_AWADDR  = a;
        ifc.s_axi_control_WDATA   = d;
        ifc.s_axi_control_AWVALID = 1'b1;
        ifc.s_axi_control_WVALID  = 1'b1;
        do begin @(negedge ap_clk); n++; end
        while (!(ifc.s_axi_control_AWREADY && ifc.s_axi_control_WREADY) && n < 20);
        check("aw_ready", 32'(ifc.s_axi_control_AWREADY && ifc.s_axi_control_WREADY), 32'd1);
        @(posedge ap_clk); #1;
        ifc.s_axi_control_AWVALID = 1'b0;
        ifc.s_axi_control_WVALID  = 1'b0;
        @(negedge ap_clk);
        check("bvalid", 32'(ifc.s_axi_control_BVALID), 32'd1);
        check("bresp", 32'(ifc.s_axi_control_BRESP), 32'd0);
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
        int n = 0;
        ifc.s_axi_control_ARADDR  = a;
        ifc.s_axi_control_ARVALID = 1'b1;
        do begin @(negedge ap_clk); n++; end
        while (!ifc.s_axi_control_ARREADY && n < 20);
        @(posedge ap_clk); #1;
        ifc.s_axi_control_ARVALID = 1'b0;
        n = 0;
        do begin @(negedge ap_clk); n++; end
        while (!ifc.s_axi_control_RVALID && n < 20);
        check("rvalid", 32'(ifc.s_axi_control_RVALID), 32'd1);
        d = ifc.s_axi_control_RDATA;
    endtask

    task automatic start_run(input logic [31:0] s, input logic [31:0] nb, input logic [31:0] num);
        axi_write(6'h10, s);
        axi_write(6'h1C, nb);
        axi_write(6'h24, num);
        push_run(s, nb, num);
        axi_write(6'h00, 32'h1);
    endtask

    task automatic finish_run(input int budget);
        int n = 0;
        logic [31:0] d;
        while ((exp_q.size() != 0 || ifc.out_stream_TVALID) && n < budget) begin
            @(negedge ap_clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge ap_clk);
        #1;
        axi_read(6'h00, d);
        check("ctrl_done", d, 32'h6);
        axi_read(6'h00, d);
        check("ctrl_cleared", d, 32'h4);
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] nb, input logic [31:0] num, input bit rnd);
        rnd_ready = rnd;
        start_run(s, nb, num);
        finish_run(int'(num) * 8 + 200);
        rnd_ready = 1'b0;
    endtask

    initial forever begin
        @(posedge ap_clk);
        #1;
        ifc.out_stream_TREADY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability and gap placement
    initial begin
        bit gap_chk, gap_exp, held;
        logic [7:0] hd;
        logic hl;
        beat_t e;
        gap_chk = 1'b0;
        gap_exp = 1'b0;
        held = 1'b0;
        hd = 8'b0;
        hl = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (!mon_en) begin
                gap_chk = 1'b0;
                held = 1'b0;
            end else begin
                if (gap_chk) begin
                    check("tvalid_after_beat", 32'(ifc.out_stream_TVALID), 32'(!gap_exp));
                    gap_chk = 1'b0;
                end
                if (ifc.out_stream_TVALID) begin
                    if (held) begin
                        check("tdata_stable", 32'(ifc.out_stream_TDATA), 32'(hd));
                        check("tlast_stable", 32'(ifc.out_stream_TLAST), 32'(hl));
                    end
                    if (ifc.out_stream_TREADY) begin
                        held = 1'b0;
                        if (exp_q.size() == 0) begin
                            check("unexpected_beat", 32'(exp_q.size()), 32'd1);
                        end else begin
                            e = exp_q.pop_front();
                            check("tdata", 32'(ifc.out_stream_TDATA), {31'b0, e.b});
                            check("tlast", 32'(ifc.out_stream_TLAST), {31'b0, e.last});
                            gap_chk = 1'b1;
                            gap_exp = e.gap;
                        end
                    end else begin
                        held = 1'b1;
                        hd = ifc.out_stream_TDATA;
                        hl = ifc.out_stream_TLAST;
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int n;
        ifc.s_axi_control_AWVALID = 1'b0;
        ifc.s_axi_control_AWADDR  = 6'h0;
        ifc.s_axi_control_WVALID  = 1'b0;
        ifc.s_axi_control_WDATA   = 32'h0;
        ifc.s_axi_control_WSTRB   = 4'hF;
        ifc.s_axi_control_BREADY  = 1'b1;
        ifc.s_axi_control_ARVALID = 1'b0;
        ifc.s_axi_control_ARADDR  = 6'h0;
        ifc.s_axi_control_RREADY  = 1'b1;
        ifc.out_stream_TREADY     = 1'b1;

        repeat (10) @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_tvalid", 32'(ifc.out_stream_TVALID), 32'd0);
        check("rst_awready", 32'(ifc.s_axi_control_AWREADY), 32'd0);
        check("rst_wready", 32'(ifc.s_axi_control_WREADY), 32'd0);
        check("rst_arready", 32'(ifc.s_axi_control_ARREADY), 32'd0);
        ap_rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge ap_clk);
        check("post_rst_awready", 32'(ifc.s_axi_control_AWREADY), 32'd1);
        check("post_rst_wready", 32'(ifc.s_axi_control_WREADY), 32'd1);
        axi_read(6'h00, d);
        check("ctrl_reset", d, 32'h4);

        run(32'h8000_0000, 32'd4, 32'd4, 1'b0);
        axi_write(6'h10, 32'h0);
        axi_read(6'h10, d);
        check("seed_readback", d, 32'h0);
        run(32'h0, 32'd5, 32'd100, 1'b0);
        run(DEF_SEED, 32'd5, 32'd100, 1'b0);

        start_run(32'h1234_5678, 32'd3, 32'd0);
        repeat (3) @(posedge ap_clk);
        #1;
        axi_read(6'h00, d);
        check("zero_len_done", d, 32'h6);
        axi_read(6'h00, d);
        check("zero_len_cleared", d, 32'h4);
        check("zero_len_tvalid", 32'(ifc.out_stream_TVALID), 32'd0);

        run(32'hCAFE_F00D, 32'd8, 32'd40, 1'b1);
        run(32'hCAFE_F00D, 32'd0, 32'd20, 1'b1);
        run(32'h0BAD_BEEF, 32'd13, 32'd30, 1'b1);

        for (int i = 0; i < 5; i++)
            run($urandom, 32'($urandom_range(0, 12)), 32'($urandom_range(1, 60)), 1'($urandom_range(0, 1)));

        start_run(32'h1234_5678, 32'd3, 32'd60);
        n = 0;
        while ((exp_q.size() > 40 || !ifc.out_stream_TVALID) && n < 500) begin
            @(negedge ap_clk);
            n++;
        end
        check("mid_run_tvalid", 32'(ifc.out_stream_TVALID), 32'd1);
        mon_en = 1'b0;
        ap_rst_n = 1'b0;
        #1;
        check("async_tvalid", 32'(ifc.out_stream_TVALID), 32'd0);
        check("async_tlast", 32'(ifc.out_stream_TLAST), 32'd0);
        check("async_awready", 32'(ifc.s_axi_control_AWREADY), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        mon_en = 1'b1;
        run(32'h1234_5678, 32'd3, 32'd60, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
